// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared BCD types, constants and helpers for the 7-segment path
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0]                bcd_digit_t;
    typedef logic [NUM_DIGITS*4-1:0]   bcd_word_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // Clamp a nibble into the legal decimal range so no non-BCD value ever escapes.
    function automatic bcd_digit_t sat_digit(input bcd_digit_t d);
        return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
    endfunction

    // Bit 0 always lit; bit i lit when any digit at position i or above is non-zero.
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input bcd_word_t w);
        logic [NUM_DIGITS-1:0] m;
        m[0] = 1'b1;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            m[i] = |(w >> (4 * i));
        end
        return m;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// rtl/bcd_digit_cnt.sv - one decimal digit of the ripple up/down counter
module bcd_digit_cnt
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_i,
    input  logic       up_i,
    input  logic       load_i,
    input  bcd_digit_t load_digit_i,
    output bcd_digit_t digit_o,
    output bcd_digit_t digit_next_o,
    output logic       carry_o
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    // Carry (up) or borrow (down) ripples to the next digit when this one rolls over.
    assign carry_o = step_i && (up_i ? (digit_q == BCD_MAX_DIGIT) : (digit_q == 4'd0));

    // Next digit: load wins, otherwise a step moves the digit by one with decimal rollover.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = sat_digit(load_digit_i);
        end else if (step_i) begin
            if (up_i) begin
                digit_d = (digit_q >= BCD_MAX_DIGIT) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? BCD_MAX_DIGIT : digit_q - 4'd1;
            end
        end
    end

    // Digit register with reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o      = digit_q;
    assign digit_next_o = digit_d;

endmodule

// File: rtl/bcd_count_src.sv
// rtl/bcd_count_src.sv - prescaled 4-digit BCD up/down counter with leading-zero mask
module bcd_count_src
    import seg_pkg::*;
#(
    parameter int TICK_DIV = 50,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [NUM_DIGITS*4-1:0] load_val,
    output logic [NUM_DIGITS*4-1:0] bcd,
    output logic [NUM_DIGITS-1:0]   dig_on,
    output logic                    tick,
    output logic                    wrap
);

    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ON_RST = LZ_BLANK ? {{(NUM_DIGITS-1){1'b0}}, 1'b1}
                                                            : {NUM_DIGITS{1'b1}};

    logic [PW-1:0]           presc_q, presc_d;
    logic [NUM_DIGITS-1:0]   dig_on_q, dig_on_d;
    logic                    tick_q;
    logic                    wrap_q;
    logic                    step_edge;
    logic [NUM_DIGITS:0]     step_chain;
    bcd_word_t               bcd_d;

    assign step_edge     = en && (presc_q == PRESC_LAST);
    // A coincident load suppresses the count, so the chain never starts on a load cycle.
    assign step_chain[0] = step_edge && !load;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_cnt u_digit (
            .clk          (clk),
            .rst          (rst),
            .step_i       (step_chain[g]),
            .up_i         (up),
            .load_i       (load),
            .load_digit_i (load_val[g*4 +: 4]),
            .digit_o      (bcd[g*4 +: 4]),
            .digit_next_o (bcd_d[g*4 +: 4]),
            .carry_o      (step_chain[g+1])
        );
    end

    // Prescaler next state and blanking mask computed from the next counter value.
    always_comb begin
        presc_d  = presc_q;
        dig_on_d = LZ_BLANK ? lead_zero_mask(bcd_d) : {NUM_DIGITS{1'b1}};
        if (load) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = step_edge ? '0 : presc_q + PW'(1);
        end
    end

    // Prescaler, mask and strobe registers; strobes line up with the new bcd value.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            dig_on_q <= DIG_ON_RST;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            dig_on_q <= dig_on_d;
            tick_q   <= step_chain[0];
            wrap_q   <= step_chain[NUM_DIGITS];
        end
    end

    assign dig_on = dig_on_q;
    assign tick   = tick_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_bcd_count_src.sv
// tb/tb_bcd_count_src.sv - scoreboard bench for bcd_count_src with TICK_DIV=4
module tb_bcd_count_src;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] bcd;
    logic [3:0]  dig_on;
    logic        tick;
    logic        wrap;

    bcd_count_src #(.TICK_DIV(4), .LZ_BLANK(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .bcd      (bcd),
        .dig_on   (dig_on),
        .tick     (tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic [3:0]  dig;
        logic        tick;
        logic        wrap;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;
    bit   done   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] w;
        w[3:0]   = 4'(n % 10);
        w[7:4]   = 4'((n / 10) % 10);
        w[11:8]  = 4'((n / 100) % 10);
        w[15:12] = 4'((n / 1000) % 10);
        return w;
    endfunction

    function automatic logic [3:0] lz(input logic [15:0] w);
        return {w[15:12] != 4'd0, w[15:8] != 8'd0, w[15:4] != 12'd0, 1'b1};
    endfunction

    task automatic push_exp(input int c, input logic [15:0] b, input logic [3:0] d,
                            input logic t, input logic w);
        exp_t x;
        x.cyc = c; x.bcd = b; x.dig = d; x.tick = t; x.wrap = w;
        q.push_back(x);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [15:0] eb, input logic [3:0] ed,
                           output int l);
        load     = 1'b1;
        load_val = v;
        push_exp(cyc + 1, eb, ed, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0;
        l    = cyc;
    endtask

    // Monitor: compare queued expectations at their cycle; any other tick is unexpected.
    always @(negedge clk) begin
        if (mon_on) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL missed_check cyc=%0d: expectation for cyc %0d never compared", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_chk++;
                if (bcd !== e.bcd || dig_on !== e.dig || tick !== e.tick || wrap !== e.wrap) begin
                    n_fail++;
                    $display("FAIL out_check cyc=%0d: got bcd=%h dig_on=%b tick=%b wrap=%b, want bcd=%h dig_on=%b tick=%b wrap=%b",
                             cyc, bcd, dig_on, tick, wrap, e.bcd, e.dig, e.tick, e.wrap);
                end
            end else begin
                n_chk++;
                if (tick !== 1'b0 || wrap !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_strobe cyc=%0d: got tick=%b wrap=%b bcd=%h, want tick=0 wrap=0",
                             cyc, tick, wrap, bcd);
                end
            end
            if (done) begin
                while (q.size() > 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL leftover cyc=%0d: expectation for cyc %0d not reached", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

    initial begin
        int c;
        int l;
        int t;
        rst      = 1'b1;
        en       = 1'($urandom);
        up       = 1'($urandom);
        load     = 1'b0;
        load_val = 16'($urandom);
        @(negedge clk);

        // Reset held two cycles, second one with a coincident load.
        c = cyc;
        push_exp(c + 1, 16'h0000, 4'b0001, 1'b0, 1'b0);
        push_exp(c + 2, 16'h0000, 4'b0001, 1'b0, 1'b0);
        mon_on = 1'b1;
        @(negedge clk);
        load     = 1'b1;
        load_val = 16'h1234;
        en       = 1'b1;
        @(negedge clk);

        // Up count from zero: a tick every 4 cycles for 100 steps.
        rst  = 1'b0;
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        c    = cyc;
        for (int n = 1; n <= 100; n++) begin
            push_exp(c + 4 * n, to_bcd(n), lz(to_bcd(n)), 1'b1, 1'b0);
        end
        wait_until(c + 400);

        // Up wrap 9998 -> 9999 -> 0000, wrap only for one cycle.
        do_load(16'h9998, 16'h9998, 4'b1111, l);
        push_exp(l + 4, 16'h9999, 4'b1111, 1'b1, 1'b0);
        push_exp(l + 8, 16'h0000, 4'b0001, 1'b1, 1'b1);
        push_exp(l + 9, 16'h0000, 4'b0001, 1'b0, 1'b0);
        wait_until(l + 9);

        // Down with borrow chain and down wrap.
        up = 1'b0;
        do_load(16'h1000, 16'h1000, 4'b1111, l);
        push_exp(l + 4, 16'h0999, 4'b0111, 1'b1, 1'b0);
        wait_until(l + 4);
        do_load(16'h0000, 16'h0000, 4'b0001, l);
        push_exp(l + 4, 16'h9999, 4'b1111, 1'b1, 1'b1);
        wait_until(l + 4);

        // Saturating load, then a load landing on a step edge.
        up = 1'b1;
        do_load(16'h12F4, 16'h1294, 4'b1111, l);
        wait_until(l + 3);
        do_load(16'h0042, 16'h0042, 4'b0011, l);
        push_exp(l + 4, 16'h0043, 4'b0011, 1'b1, 1'b0);
        wait_until(l + 4);

        // Freeze at prescaler=2 for 10 cycles with up toggled meanwhile.
        t = cyc;
        wait_until(t + 2);
        en = 1'b0;
        push_exp(t + 8, 16'h0043, 4'b0011, 1'b0, 1'b0);
        wait_until(t + 6);
        up = 1'b0;
        wait_until(t + 10);
        up = 1'b1;
        wait_until(t + 12);
        en = 1'b1;
        push_exp(t + 14, 16'h0044, 4'b0011, 1'b1, 1'b0);
        wait_until(t + 14);

        // Reset pulse mid-period, then counting resumes from zero.
        wait_until(t + 15);
        rst = 1'b1;
        push_exp(t + 16, 16'h0000, 4'b0001, 1'b0, 1'b0);
        wait_until(t + 16);
        rst = 1'b0;
        push_exp(t + 20, 16'h0001, 4'b0001, 1'b1, 1'b0);
        wait_until(t + 22);
        done = 1'b1;
        repeat (5) @(negedge clk);
        $display("FAIL bench_end: monitor did not close the run");
        $fatal(1);
    end

endmodule
